// File: rtl/mips_multicycle_control_if.sv
// Bus between the multicycle control sequencer and the MIPS datapath.
// The IR opcode and the memory-ready handshake flow towards the controller.
// The datapath enables and mux selects flow back from it.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;

  // Controller side
  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  // Datapath side
  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control sequencer for the multicycle MIPS datapath.
// Each instruction is walked through fetch, decode, execute, memory and
// writeback. The sequencer waits on the memory-ready handshake and parks in
// TRAP when it meets an unsupported opcode. It also counts retired
// instructions.
module mips_multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  mips_multicycle_control_if.master bus,
  output logic [3:0]              state,
  output logic                    illegal,
  output logic [RETIRE_W-1:0]     retired_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     cur_state, next_state;
  logic       retire;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_c;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // State register; reset aborts any instruction in flight and restarts at FETCH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_state <= S_FETCH;
    else        cur_state <= next_state;
  end

  // Retired-instruction counter, bumped on the edge that leaves a retiring state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      retired_count <= '0;
    else if (retire) retired_count <= retired_count + RETIRE_W'(1);
  end

  // Next-state decode and per-state control word
  always_comb begin
    next_state    = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_c     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        retire     = bus.mem_ready;
        next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_TRAP: begin
        illegal_c  = 1'b1;
        next_state = S_TRAP;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, including the FETCH strobes
  assign bus.PCWrite     = reset & pc_write;
  assign bus.PCWriteCond = reset & pc_write_cond;
  assign bus.IorD        = reset & iord;
  assign bus.MemRead     = reset & mem_read;
  assign bus.MemWrite    = reset & mem_write;
  assign bus.IRWrite     = reset & ir_write;
  assign bus.MemtoReg    = reset & mem_to_reg;
  assign bus.RegDst      = reset & reg_dst;
  assign bus.RegWrite    = reset & reg_write;
  assign bus.ALUSrcA     = reset & alu_src_a;
  assign bus.ALUSrcB     = {2{reset}} & alu_src_b;
  assign bus.ALUOp       = {2{reset}} & alu_op;
  assign bus.PCSource    = {2{reset}} & pc_source;
  assign illegal         = reset & illegal_c;
  assign state           = cur_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control.
// For each issued instruction, a per-cycle expectation list is built from the
// instruction class. One negedge process compares the DUT against that list.
module tb_mips_multicycle_control;

  localparam int W = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Control word bit order:
  //   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
  localparam logic [15:0] C_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
  localparam logic [15:0] C_FETCH_GO   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
  localparam logic [15:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00};
  localparam logic [15:0] C_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
  localparam logic [15:0] C_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_MEMWR      = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00};
  localparam logic [15:0] C_RWB        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01};
  localparam logic [15:0] C_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10};
  localparam logic [15:0] C_ADDIEX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
  localparam logic [15:0] C_ADDIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_TRAP       = 16'h0000;

  typedef struct packed {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic [W-1:0] cnt;
  } cyc_t;

  logic          clock;
  logic          reset;
  logic [3:0]    state;
  logic          illegal;
  logic [W-1:0]  retired_count;

  mips_multicycle_control_if bus();

  mips_multicycle_control #(.RETIRE_W(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .state         (state),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  cyc_t         q[$];
  cyc_t         cur;
  logic         exp_valid;
  logic [W-1:0] model_count;
  int           vectors;
  int           miscompares;
  logic [15:0]  dut_ctl;

  assign dut_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUOp, bus.PCSource};

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Per-cycle comparison against the expectation list, away from the active edge
  always @(negedge clock) begin
    if (exp_valid) begin
      vectors++;
      if ({state, dut_ctl, illegal, retired_count} !== {cur.st, cur.ctl, cur.ill, cur.cnt}) begin
        miscompares++;
        $display("[TB] FAIL cycle_check t=%0t op=%b mr=%b got st=%0d ctl=%h ill=%b cnt=%0d want st=%0d ctl=%h ill=%b cnt=%0d",
                 $time, cur.op, cur.mr, state, dut_ctl, illegal, retired_count,
                 cur.st, cur.ctl, cur.ill, cur.cnt);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pushCycle(input logic [5:0] op, input logic mr, input logic [3:0] st,
                           input logic [15:0] ctl, input logic ill, input logic retires);
    cyc_t c;
    c.op  = op;
    c.mr  = mr;
    c.st  = st;
    c.ctl = ctl;
    c.ill = ill;
    c.cnt = model_count;
    q.push_back(c);
    if (retires) model_count = model_count + 1'b1;
  endtask

  // Expand one instruction into its cycle-by-cycle expectations
  task automatic issue(input logic [5:0] op, input int fetch_waits, input int mem_waits);
    for (int i = 0; i < fetch_waits; i++) pushCycle(op, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0, 1'b0);
    pushCycle(op, 1'b1, 4'd0, C_FETCH_GO, 1'b0, 1'b0);
    pushCycle(op, 1'b1, 4'd1, C_DECODE, 1'b0, 1'b0);
    case (op)
      OP_LW: begin
        pushCycle(op, 1'b1, 4'd2, C_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < mem_waits; i++) pushCycle(op, 1'b0, 4'd3, C_MEMRD, 1'b0, 1'b0);
        pushCycle(op, 1'b1, 4'd3, C_MEMRD, 1'b0, 1'b0);
        pushCycle(op, 1'b1, 4'd4, C_MEMWB, 1'b0, 1'b1);
      end
      OP_SW: begin
        pushCycle(op, 1'b1, 4'd2, C_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < mem_waits; i++) pushCycle(op, 1'b0, 4'd5, C_MEMWR, 1'b0, 1'b0);
        pushCycle(op, 1'b1, 4'd5, C_MEMWR, 1'b0, 1'b1);
      end
      OP_R: begin
        pushCycle(op, 1'b1, 4'd6, C_EXEC, 1'b0, 1'b0);
        pushCycle(op, 1'b1, 4'd7, C_RWB, 1'b0, 1'b1);
      end
      OP_BEQ:  pushCycle(op, 1'b1, 4'd8, C_BRANCH, 1'b0, 1'b1);
      OP_J:    pushCycle(op, 1'b1, 4'd9, C_JUMP, 1'b0, 1'b1);
      OP_ADDI: begin
        pushCycle(op, 1'b1, 4'd10, C_ADDIEX, 1'b0, 1'b0);
        pushCycle(op, 1'b1, 4'd11, C_ADDIWB, 1'b0, 1'b1);
      end
      default: begin
        for (int i = 0; i < 10; i++) pushCycle(op, (i % 2) == 1, 4'd12, C_TRAP, 1'b1, 1'b0);
      end
    endcase
  endtask

  // Play queued cycles; each is driven just after a rising edge
  task automatic applyStimulus();
    while (q.size() > 0) begin
      cur           = q.pop_front();
      bus.opcode    = cur.op;
      bus.mem_ready = cur.mr;
      exp_valid     = 1'b1;
      @(posedge clock);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  task automatic doReset();
    reset         = 1'b0;
    model_count   = '0;
    bus.mem_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("reset_outputs", {7'd0, state, dut_ctl, illegal, retired_count}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;
    exp_valid     = 1'b0;
    model_count   = '0;
    vectors       = 0;
    miscompares   = 0;
    cur           = '0;

    doReset();

    issue(OP_LW, 0, 0);
    applyStimulus();
    checkOutput("lw_count", 32'(retired_count), 32'd1);
    checkOutput("lw_back_to_fetch", 32'(state), 32'd0);

    issue(OP_R, 0, 0);
    issue(OP_BEQ, 0, 0);
    applyStimulus();
    checkOutput("rtype_beq_count", 32'(retired_count), 32'd3);

    issue(OP_ADDI, 3, 0);
    applyStimulus();
    checkOutput("fetch_wait_addi_count", 32'(retired_count), 32'd4);

    issue(OP_SW, 0, 2);
    applyStimulus();
    checkOutput("sw_wait_count", 32'(retired_count), 32'd5);

    issue(OP_BAD, 0, 0);
    applyStimulus();
    checkOutput("trap_state", 32'(state), 32'd12);
    checkOutput("trap_illegal", 32'(illegal), 32'd1);

    doReset();
    checkOutput("post_trap_state", 32'(state), 32'd0);
    checkOutput("post_trap_illegal", 32'(illegal), 32'd0);
    checkOutput("post_trap_count", 32'(retired_count), 32'd0);

    pushCycle(OP_LW, 1'b1, 4'd0, C_FETCH_GO, 1'b0, 1'b0);
    pushCycle(OP_LW, 1'b1, 4'd1, C_DECODE, 1'b0, 1'b0);
    pushCycle(OP_LW, 1'b1, 4'd2, C_MEMADR, 1'b0, 1'b0);
    pushCycle(OP_LW, 1'b0, 4'd3, C_MEMRD, 1'b0, 1'b0);
    applyStimulus();
    bus.mem_ready = 1'b0;
    #2;
    reset       = 1'b0;
    model_count = '0;
    #1;
    checkOutput("abort_outputs", {7'd0, state, dut_ctl, illegal, retired_count}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) issue(OP_J, 0, 0);
    applyStimulus();
    checkOutput("count_before_wrap", 32'(retired_count), 32'd15);
    issue(OP_J, 0, 0);
    applyStimulus();
    checkOutput("count_after_wrap", 32'(retired_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Control sequencer for the multicycle version of the MIPS core. It replaces the single-cycle combinational ControlUnit.
- A Moore-style FSM walks each instruction through fetch, decode, execute, memory and writeback. It drives the shared-memory, PC, IR, ALU and register-file enables of the multicycle datapath.
- It stalls on a memory-ready handshake, traps on unsupported opcodes, and counts retired instructions.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  6  instruction[31:26] from IR, sampled in DECODE
- mem_ready  in  1  unified memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  write register: 0 = rt, 1 = rd
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = rs data
- ALUSrcB  out  2  ALU B: 00 = rt data, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
- ALUOp  out  2  to ALUControl: 00 = add, 01 = sub, 10 = funct-decoded
- PCSource  out  2  PC input: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state encoding, for debug and the bench
- illegal  out  1  high while in TRAP
- retired_count  out  RETIRE_W  instructions completed since reset

Behaviour:
- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB
  - 8 BRANCH, 9 JUMP, 10 ADDIEX, 11 ADDIWB, 12 TRAP
  - Codes 13-15 go to FETCH on the next edge, with all outputs 0.
- Reset (reset == 0, asynchronous):
  - state = FETCH, retired_count = 0.
  - All outputs 0 while reset is low, including the FETCH strobes; illegal = 0.
  - Reset asserted mid-instruction aborts it; nothing is retired and no strobe is emitted.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011 lw, 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - 001000 addi -> ADDIEX
  - any other -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if lw, MEMWR if sw, using the opcode still held in IR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Retires, then FETCH.
- MEMWR: MemWrite=1, IorD=1, held level for every cycle of the wait. Retires and returns to FETCH on the cycle mem_ready=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Retires, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retires whether taken or not, then FETCH.
- JUMP: PCWrite=1, PCSource=10. Retires, then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Retires, then FETCH.
- TRAP: illegal=1, all strobes 0, mem_ready ignored. Exit only via reset.
- retired_count:
  - Increments by 1 on the clock edge that leaves a retiring state; wraps from all-ones to 0.
  - Latencies with mem_ready=1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each memory wait cycle (FETCH, MEMRD, MEMWR with mem_ready=0) adds 1 cycle.
- At most one of MemRead and MemWrite is high in any cycle. PCWrite and PCWriteCond are never both high.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> state 0,1,2,3,4,0.
  - MemWB cycle: RegWrite=1, MemtoReg=1, RegDst=0.
  - retired_count 0 -> 1 after 5 cycles.
- R-type then beq, mem_ready=1 -> R-type:
  - states 0,1,6,7, with RegDst=1 in RWB.
  - beq: states 0,1,8, with PCWriteCond=1, ALUOp=01, PCSource=01.
  - retired_count = 2 after 7 cycles.
- mem_ready=0 for 3 cycles in FETCH, then 1:
  - state held at 0 and IRWrite=PCWrite=0 for 3 cycles.
  - Exactly one cycle with IRWrite=PCWrite=1, then DECODE.
- sw with mem_ready=0 for 2 cycles in MEMWR:
  - MemWrite=1, IorD=1 for 3 consecutive cycles.
  - Return to FETCH; retired_count +1 once only.
- opcode 111111 -> DECODE then TRAP (12), illegal=1, held for 10 cycles.
  - Pull reset low -> state 0, illegal 0, retired_count 0.
- Assert reset asynchronously (mid-cycle) during MEMRD -> all outputs 0 immediately, state 0.
  - After release, FETCH is first and retired_count stays 0.
- Preload retired_count near wrap (RETIRE_W=4, 15 retired) -> one more j -> count 0.
